fp_add_seq: RTL and testbench

- Parametrised, multi-cycle floating-point adder with its own sequencer. It is the next generation of the combinational exponent-compare/select control.
- Operand ordering, alignment, add/subtract, normalisation and rounding run as a state machine.
- Valid/ready handshake on input and output.
- Generic exponent/mantissa widths. Single precision is the default.

---
 rtl/fp_add_seq.sv | 190 +++++++++++++++++++
 tb/tb_fp_add_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fp_add_seq.sv
// Sequenced FP adder: order, align, add, normalise, round.
// Define FP_RNE_EN for round-to-nearest-even; default truncates.
module fp_add_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         overflow,
  output logic         underflow
);
  localparam int M = MAN_W + 5;
  localparam int SH_MAX = MAN_W + 3;
  localparam logic [EXP_W-1:0] E_ONES = '1;
  localparam logic [EXP_W:0] E_INC =
    {{EXP_W{1'b0}}, 1'b1};
  localparam logic [W-1:0] QNAN =
    {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, ROUND, DONE
  } state_t;

  state_t state;

  logic sx, sub;
  logic [EXP_W:0] ex;
  logic [EXP_W-1:0] diff;
  logic [M-1:0] mx, my;

  logic sa, sb, a_big, special;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_zero, b_zero, a_inf, b_inf;
  logic a_nan, b_nan;
  logic [W-1:0] spec_res;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf = (ea == E_ONES) && (ma == '0);
  assign b_inf = (eb == E_ONES) && (mb == '0);
  assign a_nan = (ea == E_ONES) && (ma != '0);
  assign b_nan = (eb == E_ONES) && (mb != '0);
  assign special = a_zero | b_zero | a_inf
                 | b_inf | a_nan | b_nan;
  assign a_big = a[W-2:0] >= b[W-2:0];

  always_comb begin
    spec_res = a;
    if (a_nan || b_nan
        || (a_inf && b_inf && (sa != sb)))
      spec_res = QNAN;
    else if (a_inf)
      spec_res = a;
    else if (b_inf)
      spec_res = b;
    else if (a_zero && b_zero)
      spec_res = {sa & sb, {(W-1){1'b0}}};
    else if (a_zero)
      spec_res = b;
  end

  // Sticky collects everything pushed past the S position.
  logic [31:0] sh;
  logic [M-1:0] lost_mask, my_sh;

  always_comb begin
    sh = (32'(diff) > 32'(SH_MAX))
       ? 32'(SH_MAX) : 32'(diff);
    lost_mask = ~({M{1'b1}} << sh);
    my_sh = my >> sh;
    my_sh[0] = my_sh[0] | (|(my & lost_mask));
  end

  logic [M-1:0] res;
  assign res = sub ? (mx - my) : (mx + my);

  logic [MAN_W+1:0] rm;
  logic [EXP_W:0] re;
  logic [MAN_W-1:0] rman;
  logic r_ovf;

  always_comb begin
    rm = {1'b0, mx[M-2:3]};
`ifdef FP_RNE_EN
    if (mx[2] && (mx[1] || mx[0] || mx[3]))
      rm = rm + {{(MAN_W+1){1'b0}}, 1'b1};
`endif
    re = ex;
    rman = rm[MAN_W-1:0];
    if (rm[MAN_W+1]) begin
      re = ex + E_INC;
      rman = rm[MAN_W:1];
    end
    r_ovf = (re >= {1'b0, E_ONES});
  end

  assign in_ready = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sum <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      sx <= 1'b0;
      sub <= 1'b0;
      ex <= '0;
      diff <= '0;
      mx <= '0;
      my <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          overflow <= 1'b0;
          underflow <= 1'b0;
          if (special) begin
            sum <= spec_res;
            state <= DONE;
          end else begin
            sx <= a_big ? sa : sb;
            sub <= sa ^ sb;
            ex <= {1'b0, a_big ? ea : eb};
            diff <= a_big ? (ea - eb) : (eb - ea);
            mx <= {2'b01, a_big ? ma : mb, 3'b000};
            my <= {2'b01, a_big ? mb : ma, 3'b000};
            state <= ALIGN;
          end
        end
        ALIGN: begin
          my <= my_sh;
          state <= ADD;
        end
        ADD: begin
          mx <= res;
          if (res == '0) begin
            sum <= '0;
            state <= DONE;
          end else if (res[M-1]) begin
            mx <= {1'b0, res[M-1:2],
                   res[1] | res[0]};
            ex <= ex + E_INC;
            state <= ROUND;
          end else if (res[M-2]) begin
            state <= ROUND;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          if (ex == E_INC) begin
            sum <= {sx, {(W-1){1'b0}}};
            underflow <= 1'b1;
            state <= DONE;
          end else begin
            mx <= mx << 1;
            ex <= ex - E_INC;
            if (mx[M-3]) state <= ROUND;
          end
        end
        ROUND: begin
          overflow <= r_ovf;
          sum <= r_ovf
               ? {sx, E_ONES, {MAN_W{1'b0}}}
               : {sx, re[EXP_W-1:0], rman};
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq, single precision.
// Expected sums and latencies are hand-computed.
module tb_fp_add_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic in_ready, out_valid;
  logic overflow, underflow;
  logic [31:0] sum;
  int vectors = 0;
  int miscompares = 0;

`ifdef FP_RNE_EN
  localparam logic [31:0] RND_UP = 32'h3F800001;
`else
  localparam logic [31:0] RND_UP = 32'h3F800000;
`endif

  fp_add_seq dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] va,
                        input logic [31:0] vb,
                        input logic [31:0] esum,
                        input int elat,
                        input logic eovf,
                        input logic eudf,
                        input bit hold);
    int cyc;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(elat));
    chk({tag, " sum"}, sum, esum);
    chk({tag, " ovf"}, 32'(overflow), 32'(eovf));
    chk({tag, " udf"}, 32'(underflow), 32'(eudf));
    if (!hold) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst sum", sum, 32'd0);
    chk("rst ovf", 32'(overflow), 32'd0);
    chk("rst udf", 32'(underflow), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle in_ready", 32'(in_ready), 32'd1);

    run_op("1+1", 32'h3F800000, 32'h3F800000,
           32'h40000000, 4, 1'b0, 1'b0, 1'b0);
    run_op("1-0.75", 32'h3F800000, 32'hBF400000,
           32'h3E800000, 6, 1'b0, 1'b0, 1'b0);
    run_op("max+max", 32'h7F7FFFFF, 32'h7F7FFFFF,
           32'h7F800000, 4, 1'b1, 1'b0, 1'b0);
    run_op("inf-inf", 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 1, 1'b0, 1'b0, 1'b0);
    run_op("nan+1", 32'h7F800001, 32'h3F800000,
           32'h7FC00000, 1, 1'b0, 1'b0, 1'b0);
    run_op("-inf+1", 32'hFF800000, 32'h3F800000,
           32'hFF800000, 1, 1'b0, 1'b0, 1'b0);
    run_op("0+3", 32'h00000000, 32'h40400000,
           32'h40400000, 1, 1'b0, 1'b0, 1'b0);
    run_op("-0+-0", 32'h80000000, 32'h80000000,
           32'h80000000, 1, 1'b0, 1'b0, 1'b0);
    run_op("2+1", 32'h40000000, 32'h3F800000,
           32'h40400000, 4, 1'b0, 1'b0, 1'b0);
    run_op("1+2", 32'h3F800000, 32'h40000000,
           32'h40400000, 4, 1'b0, 1'b0, 1'b0);
    run_op("-2+1", 32'hC0000000, 32'h3F800000,
           32'hBF800000, 5, 1'b0, 1'b0, 1'b0);
    run_op("x-x", 32'h40400000, 32'hC0400000,
           32'h00000000, 3, 1'b0, 1'b0, 1'b0);
    run_op("round", 32'h3F800000, 32'h33C00000,
           RND_UP, 4, 1'b0, 1'b0, 1'b0);
    run_op("tie", 32'h3F800000, 32'h33800000,
           32'h3F800000, 4, 1'b0, 1'b0, 1'b0);
    run_op("far", 32'h3F800000, 32'h0D800000,
           32'h3F800000, 4, 1'b0, 1'b0, 1'b0);
    run_op("uflow", 32'h00C00000, 32'h80800000,
           32'h00000000, 4, 1'b0, 1'b1, 1'b0);

    run_op("stall", 32'h3F800000, 32'h3F800000,
           32'h40000000, 4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall valid", 32'(out_valid), 32'd1);
      chk("stall sum", sum, 32'h40000000);
      chk("stall ovf", 32'(overflow), 32'd0);
      chk("stall in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release in_ready", 32'(in_ready), 32'd1);
    chk("release valid", 32'(out_valid), 32'd0);
    run_op("b2b 1", 32'h40000000, 32'h3F800000,
           32'h40400000, 4, 1'b0, 1'b0, 1'b0);
    run_op("b2b 2", 32'h3F800000, 32'h3F800000,
           32'h40000000, 4, 1'b0, 1'b0, 1'b0);

    a = 32'h3F800000;
    b = 32'hBF400000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("norm valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort valid", 32'(out_valid), 32'd0);
    chk("abort sum", sum, 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort idle", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("abort no out", 32'(out_valid), 32'd0);
    run_op("post rst", 32'h3F800000, 32'h3F800000,
           32'h40000000, 4, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
